// File: rtl/led_arbiter.sv
// led_arbiter: four-source round-robin owner arbiter for one 8-bit LED bank.
//   An owner keeps the bank while it requests; under contention it is forced
//   to hand over after DWELL cycles, rotating circularly so nobody starves.
// Ports:
//   clk_25mhz  in   clock, all state on rising edge
//   rst_n      in   synchronous active-low reset
//   req[3:0]   in   per-source request
//   data[31:0] in   per-source LED pattern, source i on [8i+7:8i]
//   grant[3:0] out  registered one-hot owner (0 when idle)
//   led[7:0]   out  registered pattern of the owner (0 when idle)
//   busy       out  registered, equals |grant

// Per-source pattern gate: passes a source's byte only when it is selected.
module led_arbiter_lane (
  input  logic       sel_i,
  input  logic [7:0] pat_i,
  output logic [7:0] pat_o
);
  assign pat_o = sel_i ? pat_i : 8'h00;
endmodule

module led_arbiter #(
  parameter int unsigned DWELL = 32'd25000000
) (
  input  logic        clk_25mhz,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] data,
  output logic [3:0]  grant,
  output logic [7:0]  led,
  output logic        busy
);
  localparam int unsigned NUM_SRC = 4;
  localparam logic [31:0] DWELL_M1 = 32'(DWELL - 32'd1);

  typedef enum logic {S_IDLE, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;     // last owner; search starts one past it
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  grant_q, grant_d;
  logic [7:0]  led_q, led_d;
  logic        busy_q;

  logic [NUM_SRC-1:0][7:0] data_lanes;
  logic [NUM_SRC-1:0][7:0] lane_pat;
  logic [3:0]  others;
  logic [1:0]  idle_pick, rot_pick;

  // First set bit of r, searching circularly from index s (inclusive).
  // Walk downward so the closest hit overwrites the others.
  function automatic logic [1:0] first_from(input logic [3:0] r, input logic [1:0] s);
    logic [1:0] idx;
    first_from = s;
    for (int k = 3; k >= 0; k--) begin
      idx = s + 2'(k);
      if (r[idx]) first_from = idx;
    end
  endfunction

  assign data_lanes = data;
  // Owner masked out so a rotation search only sees genuine contenders.
  assign others     = req & ~(4'b0001 << ptr_q);
  assign idle_pick  = first_from(req, ptr_q + 2'd1);
  assign rot_pick   = first_from(others, ptr_q + 2'd1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        grant_d = 4'b0000;
        if (|req) begin
          state_d = S_HOLD;
          ptr_d   = idle_pick;
          cnt_d   = '0;
          grant_d = 4'b0001 << idle_pick;
        end
      end
      S_HOLD: begin
        // In HOLD ptr_q always names the current owner.
        if (!req[ptr_q]) begin
          state_d = S_IDLE;
          grant_d = 4'b0000;
        end else if (cnt_q < DWELL_M1) begin
          cnt_d = cnt_q + 32'd1;
        end else if (|others) begin
          ptr_d   = rot_pick;
          cnt_d   = '0;
          grant_d = 4'b0001 << rot_pick;
        end
        // else: dwell expired but uncontested, cnt stays saturated
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  // led follows the grant that will be registered on this edge.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
    led_arbiter_lane u_lane (
      .sel_i (grant_d[g]),
      .pat_i (data_lanes[g]),
      .pat_o (lane_pat[g])
    );
  end

  always_comb begin
    led_d = 8'h00;
    for (int i = 0; i < NUM_SRC; i++) led_d = led_d | lane_pat[i];
  end

  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
      grant_q <= 4'b0000;
      led_q   <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      led_q   <= led_d;
      busy_q  <= |grant_d;
    end
  end

  assign grant = grant_q;
  assign led   = led_q;
  assign busy  = busy_q;
endmodule

// File: tb/tb_led_arbiter.sv
// Testbench for led_arbiter (DWELL=4): directed scenarios followed by
// randomized request/data/reset traffic. Stimulus pushes the expected
// outputs from a tenure-based reference model; a monitor pops and compares.
module tb_led_arbiter;
  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  grant;
  logic [7:0]  led;
  logic        busy;

  typedef struct packed {
    logic [3:0] grant;
    logic [7:0] led;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: owner index (-1 = none), last owner, and how many
  // cycles the current owner has held the bank so far.
  int m_owner = -1;
  int m_last  = 3;
  int m_ten   = 0;

  led_arbiter #(.DWELL(DW)) dut (
    .clk_25mhz (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data      (data),
    .grant     (grant),
    .led       (led),
    .busy      (busy)
  );

  always #20 clk = ~clk;

  function automatic int next_after(input logic [3:0] r, input int from, input int excl);
    int pick = -1;
    for (int k = 1; k <= 4; k++) begin
      int c = (from + k) % 4;
      if (pick < 0 && r[c] && c != excl) pick = c;
    end
    return pick;
  endfunction

  task automatic model_step();
    exp_t e;
    logic [31:0] d = data;
    if (!rst_n) begin
      m_owner = -1; m_last = 3; m_ten = 0;
    end else if (m_owner < 0) begin
      if (req != 4'b0) begin
        m_owner = next_after(req, m_last, -1);
        m_last  = m_owner;
        m_ten   = 1;
      end
    end else if (!req[m_owner]) begin
      m_owner = -1; m_ten = 0;
    end else if (m_ten >= DW && next_after(req, m_owner, m_owner) >= 0) begin
      m_owner = next_after(req, m_owner, m_owner);
      m_last  = m_owner;
      m_ten   = 1;
    end else if (m_ten < 1000) begin
      m_ten++;
    end
    e.grant = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
    e.led   = (m_owner < 0) ? 8'h00 : d[8*m_owner +: 8];
    e.busy  = (m_owner >= 0);
    exp_q.push_back(e);
  endtask

  // Apply inputs away from the sampling edge, then record the expectation.
  task automatic drive(input logic rn, input logic [3:0] r, input logic [31:0] d);
    @(negedge clk);
    rst_n = rn; req = r; data = d;
    model_step();
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) drive(rst_n, req, data);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant", {4'b0, grant}, {4'b0, e.grant});
        chk("led",   led,           e.led);
        chk("busy",  {7'b0, busy},  {7'b0, e.busy});
        chk("onehot", {7'b0, $onehot0(grant)}, 8'd1);
      end
    end
  end

  initial begin
    logic [3:0]  r;
    logic [31:0] d;
    rst_n = 1'b0; req = 4'b0; data = 32'h0;
    drive(1'b0, 4'b0000, 32'h0);
    drive(1'b0, 4'b0000, 32'h0);

    // Reset mid-grant, then ptr restarts at 3 so source 1 wins 1010.
    drive(1'b1, 4'b0100, 32'h00C3_0000);
    hold(2);
    drive(1'b0, 4'b0100, 32'h00C3_0000);
    drive(1'b1, 4'b1010, 32'h7700_5500);
    hold(3);
    drive(1'b0, 4'b0000, 32'h0);

    // Single source held long, then a data change.
    drive(1'b1, 4'b0001, 32'h0000_00A5);
    hold(22);
    drive(1'b1, 4'b0001, 32'h0000_003C);
    hold(3);
    drive(1'b0, 4'b0000, 32'h0);

    // Two-way contention from reset.
    drive(1'b1, 4'b0101, 32'h0011_0022);
    hold(20);
    drive(1'b0, 4'b0000, 32'h0);

    // Release mid-dwell with a pending requester.
    drive(1'b1, 4'b0010, 32'h8800_4400);
    hold(1);
    drive(1'b1, 4'b1010, 32'h8800_4400);
    drive(1'b1, 4'b1000, 32'h8800_4400);
    hold(4);
    drive(1'b0, 4'b0000, 32'h0);

    // Late contender after saturation.
    drive(1'b1, 4'b0001, 32'h0000_BB01);
    hold(9);
    drive(1'b1, 4'b0011, 32'h0000_BB01);
    hold(6);
    drive(1'b0, 4'b0000, 32'h0);

    // Full load.
    drive(1'b1, 4'b1111, 32'h4433_2211);
    hold(31);

    // Randomized traffic with sticky requests.
    r = 4'b0000; d = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) r = 4'($urandom);
      if ($urandom_range(0, 3) == 0) d = $urandom;
      drive(($urandom_range(0, 199) != 0), r, d);
    end

    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
